// File: rtl/bcd_to_binary_seq_if.sv
// Handshake and data bundle for the signed BCD-to-binary converter.
// The master drives the entry and start; the slave is the converter.
interface bcd_to_binary_seq_if #(
    parameter int unsigned OUT_WIDTH = 8
);
    logic                 start;
    logic                 sign;
    logic [3:0]           hundreds;
    logic [3:0]           tens;
    logic [3:0]           ones;
    logic [OUT_WIDTH-1:0] result;
    logic                 done;
    logic                 busy;
    logic                 error;

    modport master (
        output start, sign, hundreds, tens, ones,
        input  result, done, busy, error
    );

    modport slave (
        input  start, sign, hundreds, tens, ones,
        output result, done, busy, error
    );
endinterface

// File: rtl/bcd_to_binary_seq.sv
// Signed 3-digit BCD entry to two's-complement converter using iterative reverse double-dabble.
// One magnitude bit per clock; constant latency regardless of digit validity or range.
module bcd_to_binary_seq #(
    parameter int unsigned DIGITS    = 3,
    parameter int unsigned OUT_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    bcd_to_binary_seq_if.slave    bus
);
    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned BIN_W = $clog2(10 ** DIGITS);
    localparam int unsigned CNT_W = $clog2(BIN_W + 1);

    localparam logic [BIN_W-1:0] POS_MAX = BIN_W'((1 << (OUT_WIDTH - 1)) - 1);
    localparam logic [BIN_W-1:0] NEG_MAX = BIN_W'(1 << (OUT_WIDTH - 1));
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StFinish
    } state_e;

    state_e               r_state, w_state_next;
    logic [BCD_W-1:0]     r_bcd, w_bcd_next;
    logic [BIN_W-1:0]     r_bin, w_bin_next;
    logic [CNT_W-1:0]     r_count, w_count_next;
    logic                 r_sign, w_sign_next;
    logic                 r_invalid, w_invalid_next;
    logic [OUT_WIDTH-1:0] r_result, w_result_next;
    logic                 r_done, w_done_next;
    logic                 r_busy, w_busy_next;
    logic                 r_error, w_error_next;

    logic [BCD_W-1:0]       w_in_bcd;
    logic                   w_in_invalid;
    logic [BCD_W+BIN_W-1:0] w_shift;
    logic [BCD_W-1:0]       w_bcd_corr;
    logic [BIN_W-1:0]       w_neg;
    logic [BIN_W-1:0]       w_value;
    logic                   w_range_err;
    logic                   w_final_err;

    assign w_in_bcd = {bus.hundreds, bus.tens, bus.ones};

    always_comb begin
        w_in_invalid = 1'b0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (w_in_bcd[4*i +: 4] > 4'd9) begin
                w_in_invalid = 1'b1;
            end
        end
    end

    // Shift right, then pull each digit that now reads >= 8 back down by 3.
    always_comb begin
        w_shift    = {r_bcd, r_bin} >> 1;
        w_bcd_corr = w_shift[BCD_W+BIN_W-1:BIN_W];
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (w_bcd_corr[4*i +: 4] >= 4'd8) begin
                w_bcd_corr[4*i +: 4] = w_bcd_corr[4*i +: 4] - 4'd3;
            end
        end
    end

    assign w_neg       = BIN_W'(~r_bin + 1'b1);
    assign w_value     = r_sign ? w_neg : r_bin;
    assign w_range_err = r_sign ? (r_bin > NEG_MAX) : (r_bin > POS_MAX);
    assign w_final_err = r_invalid | w_range_err;

    always_comb begin
        w_state_next   = r_state;
        w_bcd_next     = r_bcd;
        w_bin_next     = r_bin;
        w_count_next   = r_count;
        w_sign_next    = r_sign;
        w_invalid_next = r_invalid;
        w_result_next  = r_result;
        w_done_next    = 1'b0;
        w_busy_next    = r_busy;
        w_error_next   = r_error;

        unique case (r_state)
            StIdle: begin
                w_busy_next = bus.start;
                if (bus.start) begin
                    w_bcd_next     = w_in_bcd;
                    w_sign_next    = bus.sign;
                    w_bin_next     = '0;
                    w_count_next   = '0;
                    w_invalid_next = w_in_invalid;
                    w_state_next   = StShift;
                end
            end
            StShift: begin
                w_busy_next  = 1'b1;
                w_bcd_next   = w_bcd_corr;
                w_bin_next   = w_shift[BIN_W-1:0];
                w_count_next = r_count + 1'b1;
                if (r_count == CNT_LAST) begin
                    w_state_next = StFinish;
                end
            end
            StFinish: begin
                // busy stays up through the done cycle; IDLE decides whether it drops.
                w_busy_next   = 1'b1;
                w_done_next   = 1'b1;
                w_error_next  = w_final_err;
                w_result_next = w_final_err ? '0 : OUT_WIDTH'(w_value);
                w_state_next  = StIdle;
            end
            default: begin
                w_state_next = StIdle;
                w_busy_next  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= StIdle;
            r_bcd     <= '0;
            r_bin     <= '0;
            r_count   <= '0;
            r_sign    <= 1'b0;
            r_invalid <= 1'b0;
            r_result  <= '0;
            r_done    <= 1'b0;
            r_busy    <= 1'b0;
            r_error   <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_bcd     <= w_bcd_next;
            r_bin     <= w_bin_next;
            r_count   <= w_count_next;
            r_sign    <= w_sign_next;
            r_invalid <= w_invalid_next;
            r_result  <= w_result_next;
            r_done    <= w_done_next;
            r_busy    <= w_busy_next;
            r_error   <= w_error_next;
        end
    end

    assign bus.result = r_result;
    assign bus.done   = r_done;
    assign bus.busy   = r_busy;
    assign bus.error  = r_error;
endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// Self-checking bench for bcd_to_binary_seq: directed boundaries, handshake corners,
// mid-conversion reset, full sign x 0..999 sweep and random nibble entries vs an arithmetic model.
module tb_bcd_to_binary_seq;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    bcd_to_binary_seq_if #(.OUT_WIDTH(8)) bus ();

    bcd_to_binary_seq #(
        .DIGITS   (3),
        .OUT_WIDTH(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Decimal arithmetic view of the entry, independent of the shift algorithm.
    task automatic ref_conv(input bit s, input int h, input int t, input int o,
                            output logic [7:0] res, output logic err);
        int mag;
        mag = h * 100 + t * 10 + o;
        err = (h > 9) || (t > 9) || (o > 9) || (!s && mag > 127) || (s && mag > 128);
        if (err)    res = 8'h00;
        else if (s) res = 8'((256 - mag) & 255);
        else        res = 8'(mag);
    endtask

    task automatic run_conv(input string tag, input bit s, input int h, input int t,
                            input int o, input bit scramble);
        logic [7:0] exp_res;
        logic       exp_err;
        int         lat;
        int         busy_cnt;
        bit         got;
        ref_conv(s, h, t, o, exp_res, exp_err);
        @(negedge clk);
        bus.sign     = s;
        bus.hundreds = 4'(h);
        bus.tens     = 4'(t);
        bus.ones     = 4'(o);
        bus.start    = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        busy_cnt  = bus.busy ? 1 : 0;
        lat       = 0;
        got       = 1'b0;
        for (int k = 1; k <= 40 && !got; k++) begin
            @(posedge clk);
            #1;
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                got       = 1'b1;
                lat       = k;
                bus.start = 1'b0;
            end else if (scramble) begin
                bus.start    = 1'($urandom);
                bus.sign     = 1'($urandom);
                bus.hundreds = 4'($urandom);
                bus.tens     = 4'($urandom);
                bus.ones     = 4'($urandom);
            end
        end
        check_eq({tag, ".lat"}, 32'(lat), 32'd11);
        check_eq({tag, ".res"}, 32'(bus.result), 32'(exp_res));
        check_eq({tag, ".err"}, 32'(bus.error), 32'(exp_err));
        check_eq({tag, ".busy_cycles"}, 32'(busy_cnt), 32'd12);
        @(posedge clk);
        #1;
        check_eq({tag, ".done_pulse"}, 32'(bus.done), 32'd0);
        check_eq({tag, ".busy_after"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        int first_done;
        int second_done;
        int done_seen;
        logic [7:0] exp_res;
        logic       exp_err;

        n_checks     = 0;
        n_errors     = 0;
        rst          = 1'b0;
        bus.start    = 1'b0;
        bus.sign     = 1'b0;
        bus.hundreds = 4'd0;
        bus.tens     = 4'd0;
        bus.ones     = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst.result", 32'(bus.result), 32'd0);
        check_eq("rst.done", 32'(bus.done), 32'd0);
        check_eq("rst.busy", 32'(bus.busy), 32'd0);
        check_eq("rst.error", 32'(bus.error), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        run_conv("p127", 1'b0, 1, 2, 7, 1'b0);
        run_conv("n128", 1'b1, 1, 2, 8, 1'b0);
        run_conv("n5", 1'b1, 0, 0, 5, 1'b0);
        run_conv("n0", 1'b1, 0, 0, 0, 1'b0);
        run_conv("p128", 1'b0, 1, 2, 8, 1'b0);
        run_conv("n999", 1'b1, 9, 9, 9, 1'b0);
        run_conv("badtens", 1'b0, 0, 10, 0, 1'b0);
        run_conv("scramble", 1'b0, 0, 4, 2, 1'b1);

        // start held high across done: second conversion launches on the edge after done.
        @(negedge clk);
        bus.sign     = 1'b0;
        bus.hundreds = 4'd0;
        bus.tens     = 4'd4;
        bus.ones     = 4'd2;
        bus.start    = 1'b1;
        @(posedge clk);
        #1;
        bus.sign     = 1'b1;
        bus.hundreds = 4'd0;
        bus.tens     = 4'd1;
        bus.ones     = 4'd0;
        first_done   = 0;
        second_done  = 0;
        for (int k = 1; k <= 40 && second_done == 0; k++) begin
            @(posedge clk);
            #1;
            if (k == 12) bus.start = 1'b0;
            if (bus.done) begin
                if (first_done == 0) begin
                    first_done = k;
                    check_eq("b2b.res1", 32'(bus.result), 32'h2A);
                end else begin
                    second_done = k;
                    check_eq("b2b.res2", 32'(bus.result), 32'hF6);
                end
            end
        end
        bus.start = 1'b0;
        check_eq("b2b.first_lat", 32'(first_done), 32'd11);
        check_eq("b2b.gap", 32'(second_done - first_done), 32'd12);
        @(posedge clk);
        #1;
        check_eq("b2b.idle", 32'(bus.busy), 32'd0);

        // Reset in the middle of a conversion of an out-of-range entry (error=1 beforehand).
        run_conv("pre_rst", 1'b0, 2, 0, 0, 1'b0);
        @(negedge clk);
        bus.sign     = 1'b0;
        bus.hundreds = 4'd0;
        bus.tens     = 4'd5;
        bus.ones     = 4'd5;
        bus.start    = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check_eq("midrst.result", 32'(bus.result), 32'd0);
        check_eq("midrst.done", 32'(bus.done), 32'd0);
        check_eq("midrst.busy", 32'(bus.busy), 32'd0);
        check_eq("midrst.error", 32'(bus.error), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        done_seen = 0;
        for (int k = 0; k < 15; k++) begin
            @(posedge clk);
            #1;
            if (bus.done || bus.busy) done_seen++;
        end
        check_eq("midrst.no_done", 32'(done_seen), 32'd0);
        run_conv("post_rst", 1'b0, 0, 9, 9, 1'b0);
        check_eq("post_rst.val", 32'(bus.result), 32'h63);

        for (int s = 0; s < 2; s++) begin
            for (int v = 0; v < 1000; v++) begin
                run_conv($sformatf("sweep_s%0d_v%0d", s, v), 1'(s), v / 100, (v / 10) % 10,
                         v % 10, 1'b0);
            end
        end

        for (int n = 0; n < 200; n++) begin
            bit s;
            int h;
            int t;
            int o;
            s = 1'($urandom);
            h = int'($urandom_range(0, 15));
            t = int'($urandom_range(0, 15));
            o = int'($urandom_range(0, 15));
            ref_conv(s, h, t, o, exp_res, exp_err);
            run_conv($sformatf("rand%0d_s%0d_%0h%0h%0h", n, s, h, t, o), s, h, t, o,
                     n[0] & exp_err);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/bcd_to_binary_seq.md
Name: bcd_to_binary_seq

Overview:
Sequential converter from signed 3-digit BCD entry (sign + hundreds/tens/ones) to an 8-bit two's-complement value. It is the reverse path of the switch-to-display chain and feeds decimal operator entry back into the binary datapath. Conversion uses iterative reverse double-dabble: shift right, then subtract-3 correction, one bit per clock. A start/busy/done handshake frames each conversion.

Parameters:
DIGITS, 3, number of BCD input digits; BCD shift register is 4*DIGITS bits.
OUT_WIDTH, 8, width of two's-complement result.
BIN_W, 10, derived localparam: ceil(log2(10^DIGITS)); magnitude register width and number of shift iterations.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-low reset.
start  input  1  request conversion; sampled only in IDLE.
sign  input  1  1 = negative entry, 0 = positive.
hundreds  input  4  BCD hundreds digit.
tens  input  4  BCD tens digit.
ones  input  4  BCD ones digit.
result  output  OUT_WIDTH  two's-complement value; held until next done.
done  output  1  one-cycle pulse; result/error valid.
busy  output  1  high from accepted start until done cycle inclusive.
error  output  1  invalid digit or out-of-range magnitude; updated with done.

Behaviour:
- Reset (rst low, async): state=IDLE; result=0, done=0, busy=0, error=0; internal bcd/bin/count/sign registers = 0. Reset mid-conversion aborts; no done is issued.
- States: IDLE, SHIFT, FINISH.
- IDLE: on clk edge with start=1, latch {hundreds,tens,ones} into bcd_reg, sign into sign_reg, bin_reg=0, count=0, busy=1, flag invalid if any digit >9 → SHIFT. start=0 → stay.
- SHIFT: each edge, {bcd_reg,bin_reg} shifted right 1 (bcd LSB enters bin MSB), then every 4-bit bcd digit >=8 has 3 subtracted (same cycle). count++. After BIN_W shifts (count reaches BIN_W-1 on the shifting edge) → FINISH.
- FINISH (one edge): mag=bin_reg. error=invalid | (sign=0 & mag>127) | (sign=1 & mag>128). If error: result=0. Else result = sign ? (~mag+1) truncated to OUT_WIDTH : mag. done=1 for this cycle only, busy=0 on next edge, → IDLE.
- Latency: start sampled at edge E0; done high in the cycle after edge E(BIN_W+1) = E11 for defaults; busy high cycles E0..E11.
- start while busy: ignored; inputs may change freely during conversion (latched at E0).
- start high in the done cycle: state is FINISH, not sampled; accepted the following cycle (back-to-back throughput one conversion per BIN_W+2 cycles).
- Negative zero (sign=1, 000): result=0x00, error=0.
- Boundaries: +127 → 0x7F; -128 → 0x80; +128 → error; -129 → error; 999 either sign → error.
- Invalid digit still runs full BIN_W shifts (constant latency); error=1, result=0.
- done and error are registered; result holds value between conversions; error holds until next FINISH.

Test Plan:
- Reset, then start with sign=0, 1/2/7 → done exactly 11 cycles after start edge, result=0x7F, error=0, busy high 12 cycles.
- sign=1, 1/2/8 → result=0x80, error=0; sign=1, 0/0/5 → 0xFB; sign=1, 0/0/0 → 0x00, error=0.
- sign=0, 1/2/8 → error=1, result=0x00; sign=1, 9/9/9 → error=1; tens=0xA → error=1, result=0x00, latency still 11.
- Start 0/4/2; toggle start and change digits during busy → single done, result=0x2A; start held high through done → second conversion begins next cycle, done again 12 cycles later.
- Assert rst low at cycle 5 of a conversion → all outputs 0 immediately, no done; after release, new start 0/9/9 → 0x63.
- Sweep all sign × 0..999 entries vs. reference model: result/error match; done is single-cycle pulse each time.
